blk_level_buffer: RTL and testbench

BLK_LEVEL_BUFFER -- requirements
Module: blk_level_buffer

---
 rtl/blk_pkg.sv | 30 +++
 rtl/blk_acc.sv | 38 +++
 rtl/blk_level_buffer.sv | 130 +++++++++++++
 tb/tb_blk_level_buffer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/blk_pkg.sv
// Shared helpers for the block level buffer: index/accumulator widths,
// saturating accumulation, level quantisation and level boundaries.
package blk_pkg;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One extra bit so the accumulator can hold MAX itself.
  function automatic int acc_w(input int max);
    return $clog2(max) + 1;
  endfunction

  function automatic int sat_add(input int a, input int b, input int max);
    int s;
    s = a + b;
    return (s > max) ? max : s;
  endfunction

  function automatic int raw_level(input int snap, input int shift, input int levels);
    int n;
    n = snap >> shift;
    return (n > levels - 1) ? levels - 1 : n;
  endfunction

  function automatic int boundary(input int k, input int shift);
    return k << shift;
  endfunction

endpackage

// File: rtl/blk_acc.sv
// Per-column saturating pixel-weight accumulator with end-of-segment snapshot.
module blk_acc
  import blk_pkg::*;
#(
  parameter int MAX = 4096,
  parameter int WD  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   sel_i,
  input  logic                   de_i,
  input  logic [WD-1:0]          wd_i,
  input  logic                   h_save_i,
  input  logic                   v_save_i,
  output logic [acc_w(MAX)-1:0]  snap_o
);

  localparam int AW = acc_w(MAX);

  logic [AW-1:0] acc;
  logic [AW-1:0] sum;

  assign sum = AW'(sat_add(32'(acc), 32'(wd_i), MAX));

  // v_save clears the row and takes priority over same-cycle pixels/saves.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc    <= '0;
      snap_o <= '0;
    end else if (v_save_i) begin
      acc <= '0;
    end else begin
      if (sel_i && de_i) acc <= sum;
      if (sel_i && h_save_i) snap_o <= de_i ? sum : acc;
    end
  end

endmodule

// File: rtl/blk_level_buffer.sv
// Block brightness level buffer: accumulates per-column weights, quantises each
// block row into a work bank with hysteresis, and double-buffers to a display bank.
module blk_level_buffer
  import blk_pkg::*;
#(
  parameter int HBLKS = 10,
  parameter int VBLKS = 10,
  parameter int MAX   = 4096,
  parameter int WD    = 8,
  parameter int LB    = 2,
  parameter int HYST  = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [idx_w(HBLKS)-1:0] ht_i,
  input  logic [idx_w(VBLKS)-1:0] vt_i,
  input  logic                    vs_i,
  input  logic                    h_save_i,
  input  logic                    v_save_i,
  input  logic                    de_i,
  input  logic [WD-1:0]           wd_i,
  input  logic [idx_w(HBLKS)-1:0] rht_i,
  input  logic [idx_w(VBLKS)-1:0] rvt_i,
  input  logic                    rh_save_i,
  output logic [LB-1:0]           rlvl_o,
  output logic                    rx_o,
  output logic                    frame_valid_o
);

  localparam int HW = idx_w(HBLKS);
  localparam int VW = idx_w(VBLKS);
  localparam int AW = acc_w(MAX);
  localparam int L  = 1 << LB;
  localparam int SH = $clog2(MAX) - LB;

  logic [AW-1:0] snap [HBLKS];
  logic [LB-1:0] q    [HBLKS];
  logic [LB-1:0] work [HBLKS][VBLKS];
  logic [LB-1:0] disp [HBLKS][VBLKS];

  logic          wr_ok;
  logic [VW-1:0] wr_row;
  logic          rd_hit;
  logic [HW-1:0] rd_col;
  logic [VW-1:0] rd_row;
  logic [LB-1:0] rd_lvl;

  for (genvar gi = 0; gi < HBLKS; gi++) begin : g_col
    blk_acc #(.MAX(MAX), .WD(WD)) u_acc (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .sel_i    (int'(ht_i) == gi),
      .de_i     (de_i),
      .wd_i     (wd_i),
      .h_save_i (h_save_i),
      .v_save_i (v_save_i),
      .snap_o   (snap[gi])
    );
  end

  assign wr_ok  = int'(vt_i) < VBLKS;
  assign wr_row = wr_ok ? vt_i : '0;

  // Quantise each snapshot; hold the committed level when the new one sits
  // just across an adjacent boundary.
  always_comb begin
    int s, n, o, qv;
    s  = 0;
    n  = 0;
    o  = 0;
    qv = 0;
    for (int i = 0; i < HBLKS; i++) begin
      s  = 32'(snap[i]);
      n  = raw_level(s, SH, L);
      o  = 32'(disp[i][wr_row]);
      qv = n;
      if (HYST > 0) begin
        if (n == o + 1 && s < boundary(n, SH) + HYST) qv = o;
        else if (n == o - 1 && s >= boundary(o, SH) - HYST) qv = o;
      end
      q[i] = LB'(qv);
    end
  end

  // Display copy reads the pre-edge work bank, so a coincident v_save only
  // reaches the display on the following vs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < HBLKS; i++)
        for (int j = 0; j < VBLKS; j++) begin
          work[i][j] <= '0;
          disp[i][j] <= '0;
        end
      frame_valid_o <= 1'b0;
    end else begin
      if (vs_i) begin
        for (int i = 0; i < HBLKS; i++)
          for (int j = 0; j < VBLKS; j++)
            disp[i][j] <= work[i][j];
        frame_valid_o <= 1'b1;
      end
      if (v_save_i && wr_ok)
        for (int i = 0; i < HBLKS; i++)
          work[i][wr_row] <= q[i];
    end
  end

  // Look-ahead clamps to the last column; a plain out-of-range index reads 0.
  always_comb begin
    int c;
    rd_hit = 1'b1;
    c = int'(rht_i) + (rh_save_i ? 1 : 0);
    if (c >= HBLKS) begin
      if (rh_save_i) c = HBLKS - 1;
      else           rd_hit = 1'b0;
    end
    if (int'(rvt_i) >= VBLKS) rd_hit = 1'b0;
    rd_col = rd_hit ? HW'(c) : '0;
    rd_row = rd_hit ? rvt_i : '0;
    rd_lvl = rd_hit ? disp[rd_col][rd_row] : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rlvl_o <= '0;
    else         rlvl_o <= rd_lvl;
  end

  assign rx_o = rlvl_o[LB-1];

endmodule

// File: tb/tb_blk_level_buffer.sv
// Directed self-checking bench for blk_level_buffer (10x10 blocks, MAX 4096,
// 4 levels, hysteresis margin 64).
module tb_blk_level_buffer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] ht = '0, vt = '0, rht = '0, rvt = '0;
  logic       vs = 1'b0, h_save = 1'b0, v_save = 1'b0, de = 1'b0, rh = 1'b0;
  logic [7:0] wd = '0;
  logic [1:0] rlvl;
  logic       rx, fv;

  int n_checks = 0;
  int n_fail   = 0;

  blk_level_buffer #(
    .HBLKS(10), .VBLKS(10), .MAX(4096), .WD(8), .LB(2), .HYST(64)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .ht_i(ht), .vt_i(vt), .vs_i(vs),
    .h_save_i(h_save), .v_save_i(v_save), .de_i(de), .wd_i(wd),
    .rht_i(rht), .rvt_i(rvt), .rh_save_i(rh),
    .rlvl_o(rlvl), .rx_o(rx), .frame_valid_o(fv)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int rht;
    int rvt;
    int rh;
    int lvl;
  } rd_vec_t;

  rd_vec_t vecs [$];

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input int col, input int n, input int w);
    ht = 4'(col);
    wd = 8'(w);
    de = 1'b1;
    repeat (n) cyc();
    de = 1'b0;
    wd = '0;
    h_save = 1'b1;
    cyc();
    h_save = 1'b0;
  endtask

  task automatic vsave(input int row, input bit with_vs);
    vt = 4'(row);
    v_save = 1'b1;
    vs = with_vs;
    cyc();
    v_save = 1'b0;
    vs = 1'b0;
  endtask

  task automatic commit();
    vs = 1'b1;
    cyc();
    vs = 1'b0;
  endtask

  task automatic read_chk(input string nm, input int c, input int r, input int look, input int exp);
    rht = 4'(c);
    rvt = 4'(r);
    rh  = look[0];
    cyc();
    check({nm, " rlvl"}, int'(rlvl), exp);
    check({nm, " rx"}, int'(rx), (exp >> 1) & 1);
  endtask

  initial begin
    // reset state, checked while reset is still asserted
    #1;
    check("reset rlvl", int'(rlvl), 0);
    check("reset rx", int'(rx), 0);
    check("reset frame_valid", int'(fv), 0);
    repeat (2) cyc();
    rst_n = 1'b1;
    cyc();

    // 160 x 8 = 1280 -> level 1 (clear of the 1024+64 hysteresis band)
    feed(0, 160, 8);
    vsave(0, 1'b0);
    check("frame_valid before vs", int'(fv), 0);
    commit();
    check("frame_valid after vs", int'(fv), 1);
    read_chk("basic (0,0)", 0, 0, 0, 1);

    // 600 x 255 saturates at 4096 -> level 3
    feed(0, 600, 255);
    vsave(0, 1'b0);
    commit();
    read_chk("saturate (0,0)", 0, 0, 0, 3);

    // hysteresis on block (1,2)
    feed(1, 160, 8);
    vsave(2, 1'b0);
    commit();
    read_chk("hyst base 1280", 1, 2, 0, 1);
    feed(1, 515, 4);
    vsave(2, 1'b0);
    commit();
    read_chk("hyst up 2060 holds", 1, 2, 0, 1);
    feed(1, 275, 8);
    vsave(2, 1'b0);
    commit();
    read_chk("hyst up 2200 moves", 1, 2, 0, 2);
    feed(1, 250, 8);
    vsave(2, 1'b0);
    commit();
    read_chk("hyst down 2000 holds", 1, 2, 0, 2);
    feed(1, 238, 8);
    vsave(2, 1'b0);
    commit();
    read_chk("hyst down 1904 moves", 1, 2, 0, 1);

    // row 5 column levels: 0 1 2 3 1 2 3 0 2 3
    feed(0, 0, 250);
    feed(1, 6, 250);
    feed(2, 10, 250);
    feed(3, 14, 250);
    feed(4, 6, 250);
    feed(5, 10, 250);
    feed(6, 14, 250);
    feed(7, 0, 250);
    feed(8, 10, 250);
    feed(9, 14, 250);
    vsave(5, 1'b0);
    commit();

    vecs.push_back('{0, 5, 0, 0});
    vecs.push_back('{3, 5, 0, 3});
    vecs.push_back('{2, 5, 1, 3});
    vecs.push_back('{1, 5, 1, 2});
    vecs.push_back('{9, 5, 1, 3});
    vecs.push_back('{8, 5, 1, 3});
    vecs.push_back('{8, 5, 0, 2});
    vecs.push_back('{6, 5, 1, 0});
    vecs.push_back('{4, 5, 0, 1});
    vecs.push_back('{0, 5, 1, 1});
    vecs.push_back('{10, 5, 0, 0});
    vecs.push_back('{15, 5, 0, 0});
    vecs.push_back('{12, 5, 1, 3});
    vecs.push_back('{3, 10, 0, 0});
    vecs.push_back('{2, 15, 1, 0});
    vecs.push_back('{0, 0, 0, 3});
    vecs.push_back('{1, 2, 0, 1});
    foreach (vecs[k])
      read_chk($sformatf("table[%0d] (%0d,%0d,la=%0d)", k, vecs[k].rht, vecs[k].rvt, vecs[k].rh),
               vecs[k].rht, vecs[k].rvt, vecs[k].rh, vecs[k].lvl);

    // coincident vs and v_save on row 7
    feed(0, 6, 250);
    vsave(7, 1'b0);
    read_chk("row7 before commit", 0, 7, 0, 0);
    feed(0, 14, 250);
    vsave(7, 1'b1);
    read_chk("coincident shows old", 0, 7, 0, 1);
    commit();
    read_chk("next vs shows new", 0, 7, 0, 3);

    // asynchronous reset mid-frame
    read_chk("pre-reset (0,0)", 0, 0, 0, 3);
    ht = '0;
    wd = 8'd250;
    de = 1'b1;
    repeat (10) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset rlvl", int'(rlvl), 0);
    check("async reset rx", int'(rx), 0);
    check("async reset frame_valid", int'(fv), 0);
    de = 1'b0;
    wd = '0;
    cyc();
    rst_n = 1'b1;
    cyc();
    check("frame_valid after reset", int'(fv), 0);
    read_chk("bank cleared (0,0)", 0, 0, 0, 0);
    feed(0, 6, 250);
    vsave(0, 1'b0);
    check("frame_valid before first vs", int'(fv), 0);
    commit();
    check("frame_valid after first vs", int'(fv), 1);
    read_chk("post-reset frame (0,0)", 0, 0, 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
